// File: rtl/counter_sequencer.sv
// Sequences an external counter through clear / count-to-period / expiry,
// one-shot or auto-restarting, and keeps a saturating count of expiries.
module counter_sequencer #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned EXP_WIDTH = 8
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic [WIDTH-1:0]     period_i,
    input  logic                 periodic_i,
    input  logic [WIDTH-1:0]     counter_value_i,
    output logic                 counter_enable_o,
    output logic                 counter_reset_n_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [EXP_WIDTH-1:0] expiry_count_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [EXP_WIDTH-1:0] EXP_MAX = {EXP_WIDTH{1'b1}};

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     period_q, period_d;
    logic                 periodic_q, periodic_d;
    logic [EXP_WIDTH-1:0] expiry_q, expiry_d;

    // State and configuration registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            period_q   <= '0;
            periodic_q <= 1'b0;
            expiry_q   <= '0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            periodic_q <= periodic_d;
            expiry_q   <= expiry_d;
        end
    end

    // Next-state logic; stop always wins over start and over restart
    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        periodic_d = periodic_q;
        expiry_d   = expiry_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !stop_i) begin
                    state_d    = S_CLEAR;
                    period_d   = period_i;
                    periodic_d = periodic_i;
                end
            end
            S_CLEAR: begin
                state_d = stop_i ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (counter_value_i == period_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (expiry_q != EXP_MAX) begin
                    expiry_d = expiry_q + EXP_WIDTH'(1);
                end
                state_d = (stop_i || !periodic_q) ? S_IDLE : S_CLEAR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode; reset forces the external counter clear immediately
    always_comb begin
        counter_enable_o  = 1'b0;
        counter_reset_n_o = 1'b1;
        busy_o            = 1'b1;
        done_o            = 1'b0;
        case (state_q)
            S_IDLE:  busy_o            = 1'b0;
            S_CLEAR: counter_reset_n_o = 1'b0;
            S_RUN:   counter_enable_o  = (counter_value_i != period_q);
            S_DONE:  done_o            = 1'b1;
            default: busy_o            = 1'b0;
        endcase
        if (reset_i) begin
            counter_reset_n_o = 1'b0;
        end
    end

    assign expiry_count_o = expiry_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench: external counters modelled here, expected behaviour
// derived from the phase arithmetic of a P+3 cycle sequence.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       periodic = 1'b0;
    logic [3:0] period = 4'd0;

    logic [3:0] cnt_a, cnt_b;
    logic       en_a, rn_a, busy_a, done_a;
    logic       en_b, rn_b, busy_b, done_b;
    logic [7:0] exp_a;
    logic [1:0] exp_b;

    int checks = 0;
    int failures = 0;
    int exp_total = 0;

    always #5 clk = ~clk;

    counter_sequencer #(.WIDTH(4), .EXP_WIDTH(8)) dut_a (
        .clock_i(clk), .reset_i(rst), .start_i(start), .stop_i(stop),
        .period_i(period), .periodic_i(periodic), .counter_value_i(cnt_a),
        .counter_enable_o(en_a), .counter_reset_n_o(rn_a), .busy_o(busy_a),
        .done_o(done_a), .expiry_count_o(exp_a)
    );

    counter_sequencer #(.WIDTH(4), .EXP_WIDTH(2)) dut_b (
        .clock_i(clk), .reset_i(rst), .start_i(start), .stop_i(stop),
        .period_i(period), .periodic_i(periodic), .counter_value_i(cnt_b),
        .counter_enable_o(en_b), .counter_reset_n_o(rn_b), .busy_o(busy_b),
        .done_o(done_b), .expiry_count_o(exp_b)
    );

    // External counters: synchronous active-low clear, wrapping increment
    always @(posedge clk) begin
        if (!rn_a) cnt_a <= 4'd0; else if (en_a) cnt_a <= cnt_a + 4'd1;
        if (!rn_b) cnt_b <= 4'd0; else if (en_b) cnt_b <= cnt_b + 4'd1;
    end

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    // Expected outputs t cycles after the accepting start edge
    function automatic void model(input int p, input bit per, input int t,
                                  output bit b, output bit d, output bit e,
                                  output bit r, output int cv);
        int j;
        if (!per && t > p + 2) begin
            b = 1'b0; d = 1'b0; e = 1'b0; r = 1'b1; cv = p;
            return;
        end
        j  = t % (p + 3);
        b  = 1'b1;
        d  = (j == p + 2);
        e  = (j >= 1) && (j <= p);
        r  = (j != 0);
        cv = (j == 0) ? -1 : ((j == p + 2) ? p : j - 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        exp_total = 0;
    endtask

    // Launch one sequence and compare every cycle until idle or stopped
    task automatic run_sequence(input int p, input bit per, input int n_done, input bit scramble);
        bit b, d, e, r;
        int cv;
        int dones = 0;
        int extra = -1;
        period = 4'(p); periodic = per; start = 1'b1; stop = 1'b0;
        step();
        start = 1'b0;
        for (int t = 0; t < 400; t++) begin
            model(p, per, t, b, d, e, r, cv);
            checks++;
            if (busy_a !== b) begin failures++; $display("FAIL busy p=%0d t=%0d: got %0b expected %0b", p, t, busy_a, b); end
            checks++;
            if (done_a !== d) begin failures++; $display("FAIL done p=%0d t=%0d: got %0b expected %0b", p, t, done_a, d); end
            checks++;
            if (en_a !== e) begin failures++; $display("FAIL enable p=%0d t=%0d: got %0b expected %0b", p, t, en_a, e); end
            checks++;
            if (rn_a !== r) begin failures++; $display("FAIL clear_n p=%0d t=%0d: got %0b expected %0b", p, t, rn_a, r); end
            if (cv >= 0) begin
                checks++;
                if (cnt_a !== 4'(cv)) begin failures++; $display("FAIL counter p=%0d t=%0d: got %0d expected %0d", p, t, cnt_a, cv); end
            end
            checks++;
            if (exp_a !== 8'(sat(exp_total, 255))) begin failures++; $display("FAIL expiry p=%0d t=%0d: got %0d expected %0d", p, t, exp_a, sat(exp_total, 255)); end
            checks++;
            if (exp_b !== 2'(sat(exp_total, 3))) begin failures++; $display("FAIL expiry_sat p=%0d t=%0d: got %0d expected %0d", p, t, exp_b, sat(exp_total, 3)); end
            if (d) begin exp_total++; dones++; end
            if (!per && t >= p + 4) return;
            if (per && dones >= n_done) begin
                if (extra < 0) extra = scramble ? $urandom_range(0, p + 2) : 0;
                if (extra == 0) begin
                    stop = 1'b1;
                    start = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
                    step();
                    stop = 1'b0; start = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        checks++;
                        if (busy_a !== 1'b0 || done_a !== 1'b0 || en_a !== 1'b0 || rn_a !== 1'b1) begin
                            failures++;
                            $display("FAIL stop_idle p=%0d k=%0d: got busy=%0b done=%0b en=%0b rn=%0b expected 0 0 0 1", p, k, busy_a, done_a, en_a, rn_a);
                        end
                        checks++;
                        if (exp_a !== 8'(sat(exp_total, 255))) begin failures++; $display("FAIL stop_expiry p=%0d: got %0d expected %0d", p, exp_a, sat(exp_total, 255)); end
                        step();
                    end
                    return;
                end
                extra--;
            end
            if (scramble) begin
                period   = 4'($urandom_range(0, 15));
                periodic = 1'($urandom_range(0, 1));
                start    = b ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            step();
        end
        failures++;
        $display("FAIL timeout p=%0d: got no end of sequence expected idle within 400 cycles", p);
    endtask

    task automatic test_reset();
        step();
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || en_a !== 1'b0 || exp_a !== 8'd0 || exp_b !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: got busy=%0b done=%0b en=%0b exp=%0d/%0d expected 0 0 0 0/0", busy_a, done_a, en_a, exp_a, exp_b);
        end
        checks++;
        if (rn_a !== 1'b0) begin failures++; $display("FAIL reset_clear_n: got %0b expected 0", rn_a); end
        rst = 1'b0;
        #1;
        checks++;
        if (rn_a !== 1'b1) begin failures++; $display("FAIL release_clear_n: got %0b expected 1", rn_a); end
        step();
        checks++;
        if (busy_a !== 1'b0 || cnt_a !== 4'd0) begin failures++; $display("FAIL post_reset: got busy=%0b cnt=%0d expected 0 0", busy_a, cnt_a); end
        exp_total = 0;
    endtask

    task automatic test_one_shot();
        run_sequence(5, 1'b0, 1, 1'b0);
        checks++;
        if (exp_a !== 8'd1 || cnt_a !== 4'd5) begin failures++; $display("FAIL one_shot_end: got exp=%0d cnt=%0d expected 1 5", exp_a, cnt_a); end
    endtask

    task automatic test_periodic();
        do_reset();
        run_sequence(2, 1'b1, 4, 1'b0);
        checks++;
        if (exp_a !== 8'd4) begin failures++; $display("FAIL periodic_count: got %0d expected 4", exp_a); end
    endtask

    task automatic test_edges();
        run_sequence(0, 1'b0, 1, 1'b0);
        run_sequence(15, 1'b0, 1, 1'b0);
        run_sequence(0, 1'b1, 3, 1'b0);
        run_sequence(15, 1'b1, 2, 1'b0);
    endtask

    task automatic test_collisions();
        logic [3:0] held;
        held = cnt_a;
        start = 1'b1; stop = 1'b1; period = 4'd7; periodic = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (busy_a !== 1'b0 || cnt_a !== held) begin failures++; $display("FAIL start_stop_idle k=%0d: got busy=%0b cnt=%0d expected 0 %0d", k, busy_a, cnt_a, held); end
        end
        start = 1'b0; stop = 1'b0;
        run_sequence(3, 1'b0, 1, 1'b1);
        run_sequence(4, 1'b1, 2, 1'b1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        period = 4'd6; periodic = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t < 4; t++) step();
        checks++;
        if (cnt_a !== 4'd3 || busy_a !== 1'b1) begin failures++; $display("FAIL pre_abort: got cnt=%0d busy=%0b expected 3 1", cnt_a, busy_a); end
        rst = 1'b1;
        #1;
        checks++;
        if (rn_a !== 1'b0) begin failures++; $display("FAIL abort_clear_n: got %0b expected 0", rn_a); end
        step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (busy_a !== 1'b0 || done_a !== 1'b0 || exp_a !== 8'd0) begin
                failures++;
                $display("FAIL abort k=%0d: got busy=%0b done=%0b exp=%0d expected 0 0 0", k, busy_a, done_a, exp_a);
            end
            step();
        end
        exp_total = 0;
    endtask

    task automatic test_saturation();
        do_reset();
        run_sequence(1, 1'b1, 5, 1'b0);
        checks++;
        if (exp_b !== 2'd3 || exp_a !== 8'd5) begin failures++; $display("FAIL saturation: got %0d/%0d expected 3/5", exp_b, exp_a); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            run_sequence($urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom_range(1, 3), 1'b1);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (busy_a !== 1'b0) begin failures++; $display("FAIL random_gap n=%0d: got busy=%0b expected 0", n, busy_a); end
                step();
            end
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_periodic();
        test_edges();
        test_collisions();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the width of the sequenced counter and of the period.
REQ-002 SHALL have parameter EXP_WIDTH, default 8, giving the width of the expiry counter.
REQ-003 SHALL have port clock_i, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start_i, input, 1 bit: request to start a count sequence.
REQ-006 SHALL have port stop_i, input, 1 bit: abort the sequence and return to idle.
REQ-007 SHALL have port period_i, input, WIDTH bits: terminal count, sampled on an accepted start.
REQ-008 SHALL have port periodic_i, input, 1 bit: 1 = auto-restart after expiry, 0 = one-shot; sampled on an accepted start.
REQ-009 SHALL have port counter_value_i, input, WIDTH bits: current value of the external counter.
REQ-010 SHALL have port counter_enable_o, output, 1 bit: count enable to the external counter.
REQ-011 SHALL have port counter_reset_n_o, output, 1 bit: active-low clear to the external counter.
REQ-012 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port done_o, output, 1 bit: one-cycle expiry pulse.
REQ-014 SHALL have port expiry_count_o, output, EXP_WIDTH bits: number of expiries since reset.

Function
REQ-015 SHALL implement the four states IDLE, CLEAR, RUN and DONE in a registered state machine.
REQ-016 In IDLE, an accepted start_i SHALL latch period_i into period_q and periodic_i into periodic_q, and SHALL move the state to CLEAR.
REQ-017 In IDLE, counter_enable_o SHALL be 0 and counter_reset_n_o SHALL be 1, so the counter holds its value.
REQ-018 In CLEAR, counter_reset_n_o SHALL be 0 for exactly one cycle, counter_enable_o SHALL be 0, and the next state SHALL be RUN.
REQ-019 In RUN, counter_enable_o SHALL equal (counter_value_i != period_q), combinationally.
REQ-020 In RUN, when counter_value_i == period_q, the next state SHALL be DONE.
REQ-021 In DONE, done_o SHALL be 1 and counter_enable_o SHALL be 0.
REQ-022 In DONE, the next state SHALL be CLEAR if periodic_q == 1, and IDLE otherwise.
REQ-023 done_o SHALL be 1 only in DONE.
REQ-024 Latency: if start_i is accepted at edge k, done_o SHALL be high in the cycle following edge k+P+2, where P = period_q.
REQ-025 Periodic mode SHALL produce one done_o pulse every P+3 cycles.
REQ-026 P = 0 SHALL be legal: RUN lasts one cycle with counter_enable_o = 0.
REQ-027 stop_i SHALL have priority in CLEAR, RUN and DONE: next state IDLE, and no done_o pulse on the following cycle.
REQ-028 If stop_i and start_i are high together in IDLE, the block SHALL stay in IDLE.
REQ-029 start_i SHALL be ignored while busy_o = 1; period_q and periodic_q SHALL remain unchanged.
REQ-030 Changes on period_i or periodic_i while busy SHALL have no effect on the running sequence.
REQ-031 expiry_count_o SHALL increment by 1 on each cycle spent in DONE.
REQ-032 expiry_count_o SHALL saturate at 2^EXP_WIDTH-1 and never wrap.
REQ-033 If counter_value_i exceeds period_q in RUN (external disturbance), counter_enable_o SHALL stay 1 until the counter wraps to period_q; no error flag.

Reset
REQ-034 While reset_i = 1, counter_reset_n_o SHALL be 0, combinationally from reset_i.
REQ-035 At the first edge with reset_i = 1: state IDLE, period_q = 0, periodic_q = 0, expiry_count_o = 0, busy_o = 0, done_o = 0, counter_enable_o = 0.
REQ-036 reset_i SHALL override start_i and stop_i.
REQ-037 reset_i asserted mid-sequence SHALL abort it with no done_o pulse.

Verification
REQ-038 One-shot: start_i=1 for 1 cycle with period_i=5, periodic_i=0 -> counter_reset_n_o low 1 cycle; counter runs 0..5; done_o high exactly once, 7 cycles after the start edge; then IDLE with counter_value_i holding 5 and expiry_count_o=1.
REQ-039 Periodic: period_i=2, periodic_i=1 -> done_o pulses every 5 cycles; after 4 pulses expiry_count_o=4; stop_i=1 for 1 cycle -> IDLE next cycle, no further pulses.
REQ-040 Edges: period_i=0 -> done_o 2 cycles after the start edge; period_i=15 -> done_o at 17 cycles, and counter_enable_o never high while counter_value_i=15.
REQ-041 Collisions: start_i re-pulsed in RUN with period_i=9 -> ignored, original period kept; start_i and stop_i together in IDLE -> remains IDLE.
REQ-042 Reset: reset_i=1 in RUN at counter_value_i=3 -> counter_reset_n_o=0, next state IDLE, expiry_count_o=0, no done_o pulse.
REQ-043 Saturation: EXP_WIDTH=2 in periodic mode -> expiry_count_o goes 1, 2, 3, 3, 3.
